// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// pulses the IR load enable, and holds the instruction valid while it executes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | request at pc, wait for ack (bounded by ACK_TIMEOUT cycles)
// DECODE  | one cycle, instruction valid, pc advances by one
// EXEC    | instruction valid until exec_done_i; optional redirect/halt
// HALT    | idle, no request, waits for resume_i
// ERROR   | fetch timed out; sticky until rst
module fetch_ctrl #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [11:0] imem_addr_o,
    input  logic        imem_ack_i,
    output logic        ir_load_o,
    output logic        inst_valid_o,
    input  logic        exec_done_i,
    input  logic        pc_load_i,
    input  logic [11:0] pc_target_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic [11:0] pc_o,
    output logic [2:0]  state_o,
    output logic        halted_o,
    output logic        bus_err_o,
    output logic [15:0] retired_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_HALT   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    // Last wait-count value that may still be accepted before timing out.
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [11:0] pc, pc_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic [15:0] retired, retired_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            wait_cnt <= 8'd0;
            retired  <= 16'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            wait_cnt <= wait_cnt_nxt;
            retired  <= retired_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        wait_cnt_nxt = wait_cnt;
        retired_nxt  = retired;
        case (state)
            S_FETCH: begin
                if (imem_ack_i) begin
                    state_nxt    = S_DECODE;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                pc_nxt    = pc + 12'd1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done_i) begin
                    retired_nxt = retired + 16'd1;
                    if (pc_load_i)
                        pc_nxt = pc_target_i;
                    state_nxt = halt_i ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (resume_i)
                    state_nxt = S_FETCH;
            end
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_ERROR;
        endcase
    end

    // The request is masked by rst so an ack landing in a reset cycle cannot load the IR.
    assign imem_req_o   = (state == S_FETCH) && !rst;
    assign imem_addr_o  = pc;
    assign ir_load_o    = imem_req_o && imem_ack_i;
    assign inst_valid_o = (state == S_DECODE) || (state == S_EXEC);
    assign pc_o         = pc;
    assign state_o      = state;
    assign halted_o     = (state == S_HALT);
    assign bus_err_o    = (state == S_ERROR);
    assign retired_o    = retired;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table plus hand-written
// timeout, error-stickiness and PC-wrap/halt sequences.
module tb_fetch_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst, ack, ed, pl, hlt, res;
    logic [11:0] tgt;

    logic        req0, irl0, iv0, halted0, berr0;
    logic [11:0] addr0, pc0;
    logic [2:0]  st0;
    logic [15:0] ret0;

    logic        req1, irl1, iv1, halted1, berr1;
    logic [11:0] addr1, pc1;
    logic [2:0]  st1;
    logic [15:0] ret1;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(12'h000), .ACK_TIMEOUT(15)) u0 (
        .clk(clk), .rst(rst), .imem_req_o(req0), .imem_addr_o(addr0), .imem_ack_i(ack),
        .ir_load_o(irl0), .inst_valid_o(iv0), .exec_done_i(ed), .pc_load_i(pl),
        .pc_target_i(tgt), .halt_i(hlt), .resume_i(res), .pc_o(pc0), .state_o(st0),
        .halted_o(halted0), .bus_err_o(berr0), .retired_o(ret0)
    );

    fetch_ctrl #(.RESET_PC(12'hFFF), .ACK_TIMEOUT(15)) u1 (
        .clk(clk), .rst(rst), .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(ack),
        .ir_load_o(irl1), .inst_valid_o(iv1), .exec_done_i(ed), .pc_load_i(pl),
        .pc_target_i(tgt), .halt_i(hlt), .resume_i(res), .pc_o(pc1), .state_o(st1),
        .halted_o(halted1), .bus_err_o(berr1), .retired_o(ret1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ack;
        logic        ed;
        logic        pl;
        logic [11:0] tgt;
        logic        hlt;
        logic        res;
        logic        req;
        logic [11:0] addr;
        logic        irl;
        logic        iv;
        logic [2:0]  st;
        logic        halted;
        logic        berr;
        logic [15:0] ret;
    } vec_t;

    vec_t tv [29];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic e, input logic p,
                         input logic [11:0] t, input logic h, input logic s);
        rst = r; ack = a; ed = e; pl = p; tgt = t; hlt = h; res = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_n;
        bit seen;

        //          rst ack ed pl tgt      hlt res | req addr     irl iv st    hlt berr ret
        tv[0]  = '{H, H, L, L, 12'h000, L, L,  L, 12'h000, L, L, 3'd0, L, L, 16'd0};
        tv[1]  = '{L, H, H, L, 12'h000, L, L,  H, 12'h000, H, L, 3'd0, L, L, 16'd0};
        tv[2]  = '{L, L, H, L, 12'h000, L, L,  L, 12'h000, L, H, 3'd1, L, L, 16'd0};
        tv[3]  = '{L, L, H, L, 12'h000, L, L,  L, 12'h001, L, H, 3'd2, L, L, 16'd0};
        tv[4]  = '{L, H, H, L, 12'h000, L, L,  H, 12'h001, H, L, 3'd0, L, L, 16'd1};
        tv[5]  = '{L, L, H, L, 12'h000, L, L,  L, 12'h001, L, H, 3'd1, L, L, 16'd1};
        tv[6]  = '{L, L, H, L, 12'h000, L, L,  L, 12'h002, L, H, 3'd2, L, L, 16'd1};
        tv[7]  = '{L, H, H, L, 12'h000, L, L,  H, 12'h002, H, L, 3'd0, L, L, 16'd2};
        tv[8]  = '{L, L, H, L, 12'h000, L, L,  L, 12'h002, L, H, 3'd1, L, L, 16'd2};
        tv[9]  = '{L, L, H, L, 12'h000, L, L,  L, 12'h003, L, H, 3'd2, L, L, 16'd2};
        // four wait cycles, ack on the fifth request cycle
        tv[10] = '{L, L, L, L, 12'h000, L, L,  H, 12'h003, L, L, 3'd0, L, L, 16'd3};
        tv[11] = '{L, L, L, L, 12'h000, L, L,  H, 12'h003, L, L, 3'd0, L, L, 16'd3};
        tv[12] = '{L, L, L, L, 12'h000, L, L,  H, 12'h003, L, L, 3'd0, L, L, 16'd3};
        tv[13] = '{L, L, L, L, 12'h000, L, L,  H, 12'h003, L, L, 3'd0, L, L, 16'd3};
        tv[14] = '{L, H, L, L, 12'h000, L, L,  H, 12'h003, H, L, 3'd0, L, L, 16'd3};
        tv[15] = '{L, L, L, L, 12'h000, L, L,  L, 12'h003, L, H, 3'd1, L, L, 16'd3};
        // redirect/halt/resume without exec_done: all ignored
        tv[16] = '{L, L, L, H, 12'h0A5, H, H,  L, 12'h004, L, H, 3'd2, L, L, 16'd3};
        tv[17] = '{L, L, H, H, 12'h010, L, L,  L, 12'h004, L, H, 3'd2, L, L, 16'd3};
        tv[18] = '{L, H, L, L, 12'h000, L, L,  H, 12'h010, H, L, 3'd0, L, L, 16'd4};
        tv[19] = '{L, L, L, L, 12'h000, L, L,  L, 12'h010, L, H, 3'd1, L, L, 16'd4};
        // redirect and halt together while executing the instruction at 010
        tv[20] = '{L, L, H, H, 12'h0A5, H, L,  L, 12'h011, L, H, 3'd2, L, L, 16'd4};
        tv[21] = '{L, H, L, L, 12'h000, L, L,  L, 12'h0A5, L, L, 3'd3, H, L, 16'd5};
        tv[22] = '{L, L, L, L, 12'h000, L, H,  L, 12'h0A5, L, L, 3'd3, H, L, 16'd5};
        tv[23] = '{L, H, L, L, 12'h000, L, L,  H, 12'h0A5, H, L, 3'd0, L, L, 16'd5};
        tv[24] = '{L, L, L, L, 12'h000, L, L,  L, 12'h0A5, L, H, 3'd1, L, L, 16'd5};
        tv[25] = '{L, L, H, L, 12'h000, L, L,  L, 12'h0A6, L, H, 3'd2, L, L, 16'd5};
        tv[26] = '{L, L, L, L, 12'h000, L, L,  H, 12'h0A6, L, L, 3'd0, L, L, 16'd6};
        // reset mid-fetch with a coincident ack
        tv[27] = '{H, H, L, L, 12'h000, L, L,  L, 12'h0A6, L, L, 3'd0, L, L, 16'd6};
        tv[28] = '{L, L, L, L, 12'h000, L, L,  H, 12'h000, L, L, 3'd0, L, L, 16'd0};

        drive(H, L, L, L, 12'h000, L, L);
        @(posedge clk);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].ack, tv[i].ed, tv[i].pl, tv[i].tgt, tv[i].hlt, tv[i].res);
            #1;
            chk($sformatf("v%0d req", i),    16'(req0),    16'(tv[i].req));
            chk($sformatf("v%0d addr", i),   16'(addr0),   16'(tv[i].addr));
            chk($sformatf("v%0d irload", i), 16'(irl0),    16'(tv[i].irl));
            chk($sformatf("v%0d ivalid", i), 16'(iv0),     16'(tv[i].iv));
            chk($sformatf("v%0d state", i),  16'(st0),     16'(tv[i].st));
            chk($sformatf("v%0d halted", i), 16'(halted0), 16'(tv[i].halted));
            chk($sformatf("v%0d buserr", i), 16'(berr0),   16'(tv[i].berr));
            chk($sformatf("v%0d retired", i), ret0,        tv[i].ret);
        end

        // Timeout: no ack at all
        @(negedge clk);
        drive(H, L, L, L, 12'h000, L, L);
        @(negedge clk);
        drive(L, L, L, L, 12'h000, L, L);
        #1;
        req_n = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (req0) begin
                req_n++;
                chk($sformatf("tmo c%0d buserr", i), 16'(berr0), 16'd0);
                chk($sformatf("tmo c%0d addr", i), 16'(addr0), 16'h000);
            end else begin
                seen = 1'b1;
                chk("tmo buserr_rise", 16'(berr0), 16'd1);
                chk("tmo state", 16'(st0), 16'd4);
            end
            if (!seen) begin
                @(negedge clk);
                #1;
            end
        end
        chk("tmo ended", 16'(seen), 16'd1);
        chk("tmo req_cycles", 16'(req_n), 16'd15);

        // ERROR ignores every input except rst
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(L, H, H, H, 12'h123, H, H);
            #1;
            chk($sformatf("err c%0d state", i), 16'(st0), 16'd4);
            chk($sformatf("err c%0d req", i), 16'(req0), 16'd0);
            chk($sformatf("err c%0d irload", i), 16'(irl0), 16'd0);
            chk($sformatf("err c%0d buserr", i), 16'(berr0), 16'd1);
        end
        @(negedge clk);
        drive(H, L, L, L, 12'h000, L, L);
        @(negedge clk);
        drive(L, L, L, L, 12'h000, L, L);
        #1;
        chk("err rst state", 16'(st0), 16'd0);
        chk("err rst buserr", 16'(berr0), 16'd0);
        chk("err rst req", 16'(req0), 16'd1);
        chk("err rst addr", 16'(addr0), 16'h000);

        // PC wrap and halt on the RESET_PC=FFF instance
        @(negedge clk);
        drive(H, L, L, L, 12'h000, L, L);
        @(negedge clk);
        drive(L, H, L, L, 12'h000, L, L);
        #1;
        chk("wrap fetch addr", 16'(addr1), 16'hFFF);
        chk("wrap irload", 16'(irl1), 16'd1);
        @(negedge clk);
        drive(L, L, L, L, 12'h000, L, L);
        #1;
        chk("wrap decode state", 16'(st1), 16'd1);
        @(negedge clk);
        drive(L, L, H, L, 12'h000, H, L);
        #1;
        chk("wrap exec state", 16'(st1), 16'd2);
        chk("wrap pc", 16'(pc1), 16'h000);
        @(negedge clk);
        drive(L, L, L, L, 12'h000, L, L);
        #1;
        chk("halt state", 16'(st1), 16'd3);
        chk("halt halted", 16'(halted1), 16'd1);
        chk("halt pc", 16'(pc1), 16'h000);
        chk("halt req", 16'(req1), 16'd0);
        chk("halt ivalid", 16'(iv1), 16'd0);
        chk("halt retired", ret1, 16'd1);
        @(negedge clk);
        drive(L, L, L, L, 12'h000, L, H);
        #1;
        chk("halt hold", 16'(halted1), 16'd1);
        @(negedge clk);
        drive(L, L, L, L, 12'h000, L, L);
        #1;
        chk("resume state", 16'(st1), 16'd0);
        chk("resume req", 16'(req1), 16'd1);
        chk("resume addr", 16'(addr1), 16'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 18-bit CPU. It owns the 12-bit program counter, runs the instruction-memory request/acknowledge handshake, and pulses the instruction register's load enable when a word arrives. It then holds that instruction stable while the control unit executes it. The block sits between instruction memory, the instruction register and the control unit, and is the only agent that advances or redirects the PC.

## Interface
Parameters:
- RESET_PC, 12'h000, PC value loaded on reset
- ACK_TIMEOUT, 15, maximum cycles a fetch request may wait for acknowledge (range 1-255)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  12  fetch address; equals pc_o whenever imem_req_o=1
- imem_ack_i  in  1  memory acknowledge; instruction word valid on the same cycle
- ir_load_o  out  1  load enable to instruction register (drives its ack_i)
- inst_valid_o  out  1  instruction register contents valid for decode/execute
- exec_done_i  in  1  control unit has finished the current instruction
- pc_load_i  in  1  redirect request (branch/jump taken), sampled only with exec_done_i
- pc_target_i  in  12  redirect target
- halt_i  in  1  stop after the current instruction, sampled only with exec_done_i
- resume_i  in  1  leave HALT
- pc_o  out  12  current program counter
- state_o  out  3  encoded state: FETCH=0, DECODE=1, EXEC=2, HALT=3, ERROR=4
- halted_o  out  1  high in HALT
- bus_err_o  out  1  fetch timeout, sticky until rst
- retired_o  out  16  count of completed instructions

## Operation
- Reset values:
  - pc_o=RESET_PC; state=FETCH; retired_o=0; bus_err_o=0; halted_o=0; inst_valid_o=0.
  - imem_req_o is forced 0 during the reset cycle; ir_load_o=0.
  - imem_addr_o=pc_o.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_o.
  - ir_load_o = imem_req_o & imem_ack_i (combinational), so the instruction register captures imem_data on the ack edge.
  - On ack: go to DECODE and clear the wait counter.
  - Without ack: wait counter (8-bit) increments.
  - If the counter reaches ACK_TIMEOUT with no ack: go to ERROR.
  - The request stays asserted continuously until ack or timeout and never drops early.
- DECODE (exactly 1 cycle):
  - inst_valid_o=1.
  - pc <= pc+1, modulo 2^12 (12'hFFF wraps to 12'h000).
  - Go to EXEC.
- EXEC:
  - inst_valid_o=1; wait for exec_done_i.
  - On exec_done_i: retired_o increments (wraps at 16'hFFFF→0).
  - If pc_load_i: pc <= pc_target_i. The target overrides the increment already applied.
  - Then: if halt_i, go to HALT; else go to FETCH.
  - pc_load_i and halt_i together: the PC is redirected, then the block halts.
  - pc_load_i, pc_target_i and halt_i are ignored when exec_done_i=0.
- HALT:
  - halted_o=1, inst_valid_o=0, imem_req_o=0.
  - On resume_i: go to FETCH at the current pc.
  - resume_i is ignored in all other states.
- ERROR:
  - imem_req_o=0, inst_valid_o=0, bus_err_o=1.
  - Stays here until rst; no other input has effect.
- rst asserted in any state, including mid-fetch: reset values apply on the next edge. The pending request is abandoned, and an ack arriving in the reset cycle is ignored (ir_load_o=0).

## Timing
- Zero-wait memory (ack in the first FETCH cycle) with exec_done_i in the first EXEC cycle gives 3 cycles per instruction.
- Each memory wait cycle adds 1 cycle.
- Timing within one instruction:
  - ir_load_o is high in the same cycle as imem_ack_i.
  - inst_valid_o rises the cycle after the ack.
  - The new pc_o (pc+1) is visible the cycle after DECODE.
- The first request after reset deassertion appears in the first cycle with rst=0, at address RESET_PC.
- Timeout: with no ack, imem_req_o is high for ACK_TIMEOUT cycles. bus_err_o rises on the following cycle.
- After a redirect, the next FETCH cycle presents pc_target_i on imem_addr_o.
- All outputs except ir_load_o are registered or decoded from state only. ir_load_o is the sole combinational path (imem_ack_i → ir_load_o).

## Test plan
- Reset then zero-wait memory, exec_done_i held 1:
  - Expect fetch addresses 000, 001, 002, each 3 cycles apart.
  - Expect ir_load_o pulses aligned with ack.
  - Expect retired_o=3 after 9 cycles.
- Memory acks after 4 wait cycles, ACK_TIMEOUT=15:
  - Expect imem_req_o high for 5 cycles with a constant address.
  - Expect a single ir_load_o pulse and no bus_err_o.
- No ack, ACK_TIMEOUT=15:
  - Expect imem_req_o high for exactly 15 cycles, then bus_err_o=1 and state_o=4.
  - Expect the block to stay in ERROR despite resume_i or exec_done_i, until rst.
- Redirect:
  - exec_done_i with pc_load_i=1, pc_target_i=12'h0A5 while executing the instruction at 010.
  - Expect the next request at 0A5.
  - pc_load_i without exec_done_i must be ignored.
- Halt and wrap:
  - RESET_PC=12'hFFF; exec_done_i with halt_i.
  - Expect pc_o=000, halted_o=1, no request.
  - resume_i gives a fetch at 000.
- Reset mid-fetch:
  - Assert rst during a wait cycle while ack arrives in the same cycle.
  - Expect ir_load_o=0, then FETCH at RESET_PC with retired_o=0.
